// File: rtl/uart_tx_sequencer.sv
// Streams a block of DRAM bytes into a UART Transmitter, one frame at a time,
// owning the baud enable, the active-low write strobe and the inter-byte gap.
module uart_tx_sequencer #(
   parameter int CLK_DIV   = 5208,
   parameter int ADDR_W    = 8,
   parameter int GAP_TICKS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_data,
   output logic [7:0]        tx_data,
   output logic              tx_wr_n,
   output logic              tx_tick,
   input  logic              tx_busy,
   output logic              busy,
   output logic              done,
   output logic [15:0]       byte_count,
   output logic [2:0]        state_dbg
);

   // Handshake with the Transmitter: tx_wr_n is held low in REQ until tx_busy is
   // sampled high after having been seen low, so exactly one frame is accepted.

   localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);
   localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
   localparam bit GAP_NONE = (GAP_TICKS == 0);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_REQ   = 3'd3,
      S_SEND  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t            state, state_n;
   logic [TW-1:0]     tick_cnt;
   logic [GW-1:0]     gap_cnt, gap_n;
   logic [ADDR_W-1:0] addr, addr_n;
   logic [ADDR_W-1:0] remaining, rem_n;
   logic [7:0]        tx_data_n;
   logic [15:0]       cnt_n;
   logic              done_n;
   logic              armed, armed_n;
   logic              abort_pend, abort_pend_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      tick_cnt <= '0;
      else if (tick_cnt == TICK_MAX) tick_cnt <= '0;
      else                          tick_cnt <= tick_cnt + 1'b1;
   end

   assign tx_tick   = (tick_cnt == TICK_MAX);
   assign busy      = (state != S_IDLE);
   assign mem_addr  = addr;
   assign state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         addr       <= '0;
         remaining  <= '0;
         tx_data    <= 8'h00;
         byte_count <= 16'h0000;
         done       <= 1'b0;
         armed      <= 1'b0;
         abort_pend <= 1'b0;
         gap_cnt    <= '0;
         mem_rd     <= 1'b0;
         tx_wr_n    <= 1'b1;
      end else begin
         state      <= state_n;
         addr       <= addr_n;
         remaining  <= rem_n;
         tx_data    <= tx_data_n;
         byte_count <= cnt_n;
         done       <= done_n;
         armed      <= armed_n;
         abort_pend <= abort_pend_n;
         gap_cnt    <= gap_n;
         mem_rd     <= (state_n == S_FETCH);
         tx_wr_n    <= (state_n != S_REQ);
      end
   end

   always_comb begin
      state_n      = state;
      addr_n       = addr;
      rem_n        = remaining;
      tx_data_n    = tx_data;
      cnt_n        = byte_count;
      done_n       = 1'b0;
      armed_n      = armed;
      abort_pend_n = abort_pend;
      gap_n        = gap_cnt;
      case (state)
         S_IDLE: begin
            abort_pend_n = 1'b0;
            if (start && !abort) begin
               addr_n = base_addr;
               rem_n  = length;
               if (length == '0) done_n  = 1'b1;
               else              state_n = S_FETCH;
            end
         end
         S_FETCH: state_n = abort ? S_IDLE : S_LOAD;
         S_LOAD: begin
            tx_data_n = mem_data;
            armed_n   = 1'b0;
            state_n   = abort ? S_IDLE : S_REQ;
         end
         S_REQ: begin
            // A busy seen before any idle belongs to a foreign frame in flight.
            if (tx_busy && armed) begin
               state_n      = S_SEND;
               abort_pend_n = abort;
            end else if (abort) begin
               state_n = S_IDLE;
            end else if (!tx_busy) begin
               armed_n = 1'b1;
            end
         end
         S_SEND: begin
            if (abort) abort_pend_n = 1'b1;
            if (!tx_busy) begin
               cnt_n   = byte_count + 16'd1;
               rem_n   = remaining - 1'b1;
               addr_n  = addr + 1'b1;
               gap_n   = '0;
               state_n = (abort || abort_pend) ? S_IDLE : S_GAP;
            end
         end
         S_GAP: begin
            if (abort) begin
               state_n = S_IDLE;
            end else if (GAP_NONE || (tx_tick && gap_cnt == GAP_LAST)) begin
               if (remaining == '0) begin
                  done_n  = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  state_n = S_FETCH;
               end
            end else if (tx_tick) begin
               gap_n = gap_cnt + 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench: DRAM model, behavioural Transmitter, serial-line monitor with
// an expected-byte scoreboard, and a tx_tick period watcher.
module tb_uart_tx_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  base_addr = 8'h00;
   logic [7:0]  length = 8'h00;
   logic        mem_rd;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_data;
   logic [7:0]  tx_data;
   logic        tx_wr_n;
   logic        tx_tick;
   logic        tx_busy;
   logic        busy;
   logic        done;
   logic [15:0] byte_count;
   logic [2:0]  state_dbg;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [7:0] exp_q[$];
   logic [7:0] addr_q[$];
   int done_cnt = 0;
   int rd_cnt = 0;
   int wr_low_cnt = 0;
   int tick_bad = 0;
   int tick_seen = 0;

   uart_tx_sequencer #(.CLK_DIV(4), .ADDR_W(8), .GAP_TICKS(1)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .base_addr(base_addr), .length(length),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .tx_data(tx_data), .tx_wr_n(tx_wr_n), .tx_tick(tx_tick), .tx_busy(tx_busy),
      .busy(busy), .done(done), .byte_count(byte_count), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   // DRAM model
   logic [7:0] mem [0:255];
   always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

   // Transmitter model: latches on wr_en low while idle, one bit per tick
   logic [9:0] frame;
   logic [3:0] bitn;
   logic       txd;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_busy <= 1'b0; txd <= 1'b1; bitn <= 4'd0; frame <= 10'h0;
      end else if (!tx_busy) begin
         if (!tx_wr_n) begin
            frame <= {1'b1, tx_data, 1'b0}; tx_busy <= 1'b1; bitn <= 4'd0;
         end
      end else if (tx_tick) begin
         if (bitn == 4'd10) begin
            tx_busy <= 1'b0; txd <= 1'b1;
         end else begin
            txd <= frame[bitn]; bitn <= bitn + 4'd1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // serial monitor and scoreboard
   logic       mon_act = 1'b0;
   int         mon_n = 0;
   logic [7:0] mon_sh = 8'h00;
   always @(negedge clk) begin
      if (rst) begin
         mon_act = 1'b0; mon_n = 0;
      end else if (tx_tick) begin
         if (!mon_act) begin
            if (txd == 1'b0) begin mon_act = 1'b1; mon_n = 0; end
         end else if (mon_n < 8) begin
            mon_sh[mon_n] = txd; mon_n++;
         end else begin
            check("stop_bit", 32'(txd), 32'd1);
            if (exp_q.size() == 0) check("rx_unexpected", 32'(mon_sh), 32'hFFFF_FFFF);
            else check("rx_byte", 32'(mon_sh), 32'(exp_q.pop_front()));
            mon_act = 1'b0;
         end
      end
   end

   // event counters and tick period watcher
   int  tick_gap = 0;
   logic have_prev = 1'b0;
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (mem_rd) begin rd_cnt++; addr_q.push_back(mem_addr); end
      if (!tx_wr_n) wr_low_cnt++;
      if (rst) begin
         have_prev = 1'b0; tick_gap = 0;
      end else begin
         tick_gap++;
         if (tx_tick) begin
            tick_seen++;
            if (have_prev && tick_gap != 4) tick_bad++;
            have_prev = 1'b1; tick_gap = 0;
         end
      end
   end

   // driver tasks
   task automatic pulse_start(input logic [7:0] b, input logic [7:0] l);
      @(negedge clk);
      base_addr = b; length = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0 = done_cnt;
      int ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_cnt != d0) begin ok = 1; break; end
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1; break; end
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   task automatic check_addrs(input string tag, input logic [7:0] a0, input logic [7:0] a1,
                              input logic [7:0] a2, input int n);
      logic [7:0] e [3];
      e[0] = a0; e[1] = a1; e[2] = a2;
      check({tag, "_n"}, 32'(addr_q.size()), 32'(n));
      for (int i = 0; i < n && i < addr_q.size(); i++)
         check(tag, 32'(addr_q[i]), 32'(e[i]));
   endtask

   int d0, r0, w0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C; mem[8'h12] = 8'hFF;
      mem[8'hFF] = 8'h5A; mem[8'h00] = 8'h81;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_n", 32'(tx_wr_n), 32'd1);
      check("rst_mem_rd", 32'(mem_rd), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_tx_tick", 32'(tx_tick), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_byte_count", 32'(byte_count), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: three-byte block
      exp_q = '{8'hA5, 8'h3C, 8'hFF};
      addr_q.delete(); d0 = done_cnt; r0 = rd_cnt;
      pulse_start(8'h10, 8'd3);
      wait_done("t1_done_seen", 1000);
      @(negedge clk);
      check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
      check("t1_rd_cnt", 32'(rd_cnt - r0), 32'd3);
      check("t1_byte_count", 32'(byte_count), 32'd3);
      check("t1_rx_left", 32'(exp_q.size()), 32'd0);
      check("t1_busy", 32'(busy), 32'd0);
      check_addrs("t1_addr", 8'h10, 8'h11, 8'h12, 3);

      // 2: empty transfer
      d0 = done_cnt; r0 = rd_cnt; w0 = wr_low_cnt;
      pulse_start(8'h40, 8'd0);
      check("t2_done_pulse", 32'(done), 32'd1);
      check("t2_busy", 32'(busy), 32'd0);
      repeat (10) @(negedge clk);
      check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
      check("t2_rd_cnt", 32'(rd_cnt - r0), 32'd0);
      check("t2_wr_low", 32'(wr_low_cnt - w0), 32'd0);
      check("t2_byte_count", 32'(byte_count), 32'd3);

      // 3: address wrap
      exp_q = '{8'h5A, 8'h81};
      addr_q.delete();
      pulse_start(8'hFF, 8'd2);
      wait_done("t3_done_seen", 1000);
      check_addrs("t3_addr", 8'hFF, 8'h00, 8'h00, 2);
      check("t3_byte_count", 32'(byte_count), 32'd5);
      check("t3_rx_left", 32'(exp_q.size()), 32'd0);

      // 4: abort during SEND of the first byte
      exp_q = '{8'hA5};
      d0 = done_cnt; r0 = rd_cnt;
      pulse_start(8'h10, 8'd3);
      begin
         int ok = 0;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_busy && tx_wr_n && busy) begin ok = 1; break; end
         end
         check("t4_reach_send", 32'(ok), 32'd1);
      end
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_idle("t4_idle", 400);
      repeat (40) @(negedge clk);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_done_cnt", 32'(done_cnt - d0), 32'd0);
      check("t4_rd_cnt", 32'(rd_cnt - r0), 32'd1);
      check("t4_byte_count", 32'(byte_count), 32'd6);
      check("t4_rx_left", 32'(exp_q.size()), 32'd0);

      // 5: asynchronous reset mid-frame
      pulse_start(8'h10, 8'd3);
      begin
         int ok = 0;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_busy) begin ok = 1; break; end
         end
         check("t5_frame_started", 32'(ok), 32'd1);
      end
      repeat (15) @(negedge clk);
      rst = 1'b1;
      #1;
      check("t5_wr_n", 32'(tx_wr_n), 32'd1);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_byte_count", 32'(byte_count), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 6: restart after reset, with a second start while busy
      exp_q = '{8'hA5, 8'h3C, 8'hFF};
      addr_q.delete(); d0 = done_cnt; r0 = rd_cnt;
      pulse_start(8'h10, 8'd3);
      repeat (30) @(negedge clk);
      check("t6_busy_mid", 32'(busy), 32'd1);
      pulse_start(8'h00, 8'd1);
      wait_done("t6_done_seen", 1000);
      repeat (30) @(negedge clk);
      check("t6_done_cnt", 32'(done_cnt - d0), 32'd1);
      check("t6_rd_cnt", 32'(rd_cnt - r0), 32'd3);
      check("t6_byte_count", 32'(byte_count), 32'd3);
      check("t6_rx_left", 32'(exp_q.size()), 32'd0);
      check("t6_busy_end", 32'(busy), 32'd0);
      check_addrs("t6_addr", 8'h10, 8'h11, 8'h12, 3);

      // 7: abort and start in the same idle cycle
      d0 = done_cnt;
      @(negedge clk);
      base_addr = 8'h10; length = 8'd1; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("t7_busy", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      check("t7_done_cnt", 32'(done_cnt - d0), 32'd0);

      check("tick_period_bad", 32'(tick_bad), 32'd0);
      check("tick_seen", 32'(tick_seen > 100), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
